// File: rtl/impulse_convolver.sv
// Convolves each triggered audio sample with a TAP_COUNT-tap impulse held in external coefficient memory.
// Output valid TAP_COUNT+3 cycles after a convolve trigger (1 cycle in bypass); triggers while busy are dropped and flag overrun.
module impulse_convolver #(
   parameter int TAP_COUNT  = 1024,
   parameter int ADDR_WIDTH = 16,
   parameter int ACC_WIDTH  = 48,
   parameter int SHIFT      = 15
) (
   input  logic                   audio_clk,
   input  logic                   rst_in,
   input  logic                   audio_trigger,
   input  logic                   impulse_ready,
   input  logic signed [15:0]     audio_in,
   output logic [ADDR_WIDTH-1:0]  coeff_addr,
   input  logic signed [15:0]     coeff_data,
   output logic signed [15:0]     audio_out,
   output logic                   audio_out_valid,
   output logic                   busy,
   output logic                   overrun
);
   localparam int PTR_W = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
   localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(TAP_COUNT - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32768);

   typedef enum logic [2:0] {S_RST, S_CLEAR, S_IDLE, S_ACCUM, S_DRAIN, S_OUTPUT} state_t;

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [PTR_W-1:0]              r_wr_ptr;
   logic [PTR_W-1:0]              r_k;
   logic                          r_drain;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic                          r_v1;
   logic                          r_v2;
   logic signed [15:0]            r_audio_out;
   logic                          r_byp_vld;
   logic                          r_overrun;

   logic signed [15:0]            r_hist [TAP_COUNT];
   logic signed [15:0]            r_hist_q1;
   logic signed [15:0]            r_hist_q2;

   logic                          w_hist_we;
   logic [PTR_W-1:0]              w_hist_waddr;
   logic signed [15:0]            w_hist_wdat;
   logic [PTR_W-1:0]              w_rd_addr;
   logic                          w_busy;
   logic signed [31:0]            w_prod;
   logic signed [ACC_WIDTH-1:0]   w_prod_ext;
   logic signed [ACC_WIDTH-1:0]   w_shift;
   logic signed [15:0]            w_sat;

   always_ff @(posedge audio_clk or negedge rst_in) begin
      if (!rst_in) r_state <= S_RST;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_hist_we    = 1'b0;
      w_hist_waddr = r_wr_ptr;
      w_hist_wdat  = audio_in;
      w_busy       = 1'b0;
      case (r_state)
         S_RST:   w_state_nxt = S_CLEAR;
         S_CLEAR: begin
            w_busy       = 1'b1;
            w_hist_we    = 1'b1;
            w_hist_waddr = r_k;
            w_hist_wdat  = '0;
            if (r_k == LAST_TAP) w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (audio_trigger) begin
               w_hist_we = 1'b1;
               if (impulse_ready) w_state_nxt = S_ACCUM;
            end
         end
         S_ACCUM: begin
            w_busy = 1'b1;
            if (r_k == LAST_TAP) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (r_drain) w_state_nxt = S_OUTPUT;
         end
         S_OUTPUT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_RST;
      endcase
   end

   // The newest sample is written on the trigger edge, so tap 0 reads it back a cycle later without bypass.
   assign w_rd_addr = r_wr_ptr - r_k;

   always_ff @(posedge audio_clk) begin
      if (w_hist_we) r_hist[w_hist_waddr] <= w_hist_wdat;
      r_hist_q1 <= r_hist[w_rd_addr];
      r_hist_q2 <= r_hist_q1;
   end

   assign w_prod     = coeff_data * r_hist_q2;
   assign w_prod_ext = {{(ACC_WIDTH-32){w_prod[31]}}, w_prod};
   assign w_shift    = r_acc >>> SHIFT;
   assign w_sat      = (w_shift > SAT_MAX) ? 16'sh7FFF :
                       (w_shift < SAT_MIN) ? 16'sh8000 : w_shift[15:0];

   always_ff @(posedge audio_clk or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_ptr    <= '0;
         r_k         <= '0;
         r_drain     <= 1'b0;
         r_acc       <= '0;
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_audio_out <= '0;
         r_byp_vld   <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_byp_vld <= 1'b0;
         r_v1      <= (r_state == S_ACCUM);
         r_v2      <= r_v1;
         if (r_v2) r_acc <= r_acc + w_prod_ext;
         case (r_state)
            S_CLEAR: r_k <= r_k + 1'b1;
            S_IDLE: begin
               if (audio_trigger) begin
                  if (impulse_ready) begin
                     r_acc <= '0;
                     r_k   <= '0;
                  end else begin
                     r_audio_out <= audio_in;
                     r_byp_vld   <= 1'b1;
                     r_wr_ptr    <= r_wr_ptr + 1'b1;
                  end
               end
            end
            S_ACCUM: begin
               r_k     <= r_k + 1'b1;
               r_drain <= 1'b0;
            end
            S_DRAIN: r_drain <= 1'b1;
            S_OUTPUT: begin
               r_audio_out <= w_sat;
               r_wr_ptr    <= r_wr_ptr + 1'b1;
            end
            default: ;
         endcase
         if (audio_trigger && (r_state == S_ACCUM || r_state == S_DRAIN || r_state == S_OUTPUT))
            r_overrun <= 1'b1;
      end
   end

   assign coeff_addr      = (r_state == S_ACCUM) ? ADDR_WIDTH'(r_k) : '0;
   assign audio_out       = (r_state == S_OUTPUT) ? w_sat : r_audio_out;
   assign audio_out_valid = r_byp_vld | (r_state == S_OUTPUT);
   assign busy            = w_busy;
   assign overrun         = r_overrun;

endmodule

// File: tb/tb_impulse_convolver.sv
// Bench for impulse_convolver with TAP_COUNT=8: vector table, saturation, randomized model comparison,
// overrun and mid-accumulation reset sequences.
module tb_impulse_convolver;
   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1;
   logic        audio_trigger = 1'b0;
   logic        impulse_ready = 1'b0;
   logic [15:0] audio_in = '0;
   logic [15:0] coeff_addr;
   logic [15:0] coeff_data = '0;
   logic [15:0] audio_out;
   logic        audio_out_valid;
   logic        busy;
   logic        overrun;

   logic signed [15:0] coeff_mem [T];
   logic [15:0]        c_d1 = '0;
   int                 hist_q[$];
   int                 n_checks = 0;
   int                 n_fail = 0;

   typedef struct {
      logic [15:0] x;
      logic        rdy;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [6];

   impulse_convolver #(.TAP_COUNT(T), .ADDR_WIDTH(16), .ACC_WIDTH(48), .SHIFT(15)) dut (
      .audio_clk(clk), .rst_in(rst_in), .audio_trigger(audio_trigger),
      .impulse_ready(impulse_ready), .audio_in(audio_in), .coeff_addr(coeff_addr),
      .coeff_data(coeff_data), .audio_out(audio_out), .audio_out_valid(audio_out_valid),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Coefficient memory with two cycles of read latency.
   always @(posedge clk) begin
      c_d1       <= coeff_mem[coeff_addr[2:0]];
      coeff_data <= c_d1;
   end

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic void model_reset();
      hist_q.delete();
      for (int i = 0; i < T; i++) hist_q.push_back(0);
   endfunction

   function automatic void model_push(input logic [15:0] x);
      hist_q.push_front(int'($signed(x)));
      void'(hist_q.pop_back());
   endfunction

   // y[n] = sat16(floor(sum_k c[k]*x[n-k] / 2^15))
   function automatic logic [15:0] model_conv();
      longint acc = 0;
      longint r;
      for (int k = 0; k < T; k++) acc += longint'(coeff_mem[k]) * longint'(hist_q[k]);
      r = acc >>> 15;
      if (r > 32767)  return 16'h7FFF;
      if (r < -32768) return 16'h8000;
      return r[15:0];
   endfunction

   task automatic set_coeffs(input logic [15:0] all_val);
      for (int k = 0; k < T; k++) coeff_mem[k] = all_val;
   endtask

   task automatic sample_and_check(input string nm, input logic [15:0] x, input logic rdy,
                                   input logic [15:0] exp);
      int lat = -1;
      int nb = 0;
      logic [15:0] got = '0;
      @(negedge clk);
      audio_trigger = 1'b1; audio_in = x; impulse_ready = rdy;
      @(negedge clk);
      audio_trigger = 1'b0; impulse_ready = ~rdy;
      for (int c = 1; c <= 30 && lat < 0; c++) begin
         if (c > 1) @(negedge clk);
         if (busy) nb++;
         if (audio_out_valid) begin lat = c; got = audio_out; end
      end
      check({nm, " value"}, int'(got), int'(exp));
      check({nm, " latency"}, lat, rdy ? T + 3 : 1);
      check({nm, " busy cycles"}, nb, rdy ? T + 2 : 0);
      @(negedge clk);
      check({nm, " single pulse"}, int'(audio_out_valid), 0);
      check({nm, " held"}, int'(audio_out), int'(exp));
      impulse_ready = rdy;
   endtask

   task automatic check_clear(input string nm);
      int nb = 0;
      int nv = 0;
      impulse_ready = 1'b0;
      @(negedge clk);
      rst_in = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy) nb++;
         if (audio_out_valid) nv++;
         audio_trigger = (c == 2);
         audio_in = 16'h0555;
      end
      audio_trigger = 1'b0;
      check({nm, " busy cycles"}, nb, T);
      check({nm, " no valid"}, nv, 0);
      check({nm, " overrun"}, int'(overrun), 0);
   endtask

   initial begin
      logic [15:0] x;
      logic [15:0] e;
      logic        rdy;
      int          nv;
      int          lat;
      logic [15:0] got;

      vecs[0] = '{16'd2000, 1'b1, 16'd0};
      vecs[1] = '{16'd0,    1'b1, 16'd0};
      vecs[2] = '{16'd0,    1'b1, 16'd0};
      vecs[3] = '{16'd0,    1'b1, 16'd1000};
      vecs[4] = '{16'd0,    1'b1, 16'd0};
      vecs[5] = '{16'h1234, 1'b0, 16'h1234};

      set_coeffs(16'h0000);
      model_reset();
      #1 rst_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset audio_out", int'(audio_out), 0);
      check("reset valid", int'(audio_out_valid), 0);
      check("reset busy", int'(busy), 0);
      check("reset overrun", int'(overrun), 0);
      check("reset coeff_addr", int'(coeff_addr), 0);
      check_clear("clear1");

      coeff_mem[3] = 16'h4000;
      foreach (vecs[i]) begin
         model_push(vecs[i].x);
         sample_and_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].rdy, vecs[i].exp);
      end

      set_coeffs(16'h7FFF);
      for (int i = 0; i < T; i++) begin
         model_push(16'h7FFF);
         e = (i == T - 1) ? 16'h7FFF : model_conv();
         sample_and_check($sformatf("satpos%0d", i), 16'h7FFF, 1'b1, e);
      end
      for (int i = 0; i < T; i++) begin
         model_push(16'h8000);
         e = (i == T - 1) ? 16'h8000 : model_conv();
         sample_and_check($sformatf("satneg%0d", i), 16'h8000, 1'b1, e);
      end

      for (int k = 0; k < T; k++) coeff_mem[k] = 16'($urandom_range(0, 8191) - 4096);
      for (int i = 0; i < 24; i++) begin
         x   = 16'($urandom);
         rdy = ($urandom_range(0, 3) != 0);
         model_push(x);
         e = rdy ? model_conv() : x;
         sample_and_check($sformatf("rand%0d", i), x, rdy, e);
      end
      check("no overrun before drop", int'(overrun), 0);

      set_coeffs(16'h0000);
      coeff_mem[0] = 16'h4000;
      nv = 0; lat = -1; got = '0;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (audio_out_valid) begin nv++; lat = c; got = audio_out; end
         audio_trigger = (c == 0 || c == 4);
         audio_in      = (c == 0) ? 16'd1000 : 16'd5000;
         impulse_ready = 1'b1;
      end
      audio_trigger = 1'b0;
      model_push(16'd1000);
      check("drop valid count", nv, 1);
      check("drop latency", lat, T + 3);
      check("drop value", int'(got), 500);
      check("drop overrun set", int'(overrun), 1);
      model_push(16'hFF38);
      sample_and_check("after drop", 16'hFF38, 1'b1, 16'hFF9C);
      check("overrun sticky", int'(overrun), 1);

      set_coeffs(16'h4000);
      @(negedge clk);
      audio_trigger = 1'b1; audio_in = 16'd3000; impulse_ready = 1'b1;
      @(negedge clk);
      audio_trigger = 1'b0;
      repeat (2) @(negedge clk);
      check("busy before abort", int'(busy), 1);
      rst_in = 1'b0;
      #1;
      check("abort audio_out", int'(audio_out), 0);
      check("abort busy", int'(busy), 0);
      check("abort overrun", int'(overrun), 0);
      check("abort coeff_addr", int'(coeff_addr), 0);
      check("abort valid", int'(audio_out_valid), 0);
      @(negedge clk);
      check_clear("clear2");
      model_reset();
      model_push(16'd100);
      sample_and_check("post-reset conv", 16'd100, 1'b1, model_conv());
      check("post-reset value const", int'(audio_out), 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
